// File: rtl/cla_adder.sv
// Registered two-level carry-lookahead adder, 1-cycle latency, N a multiple of 4.
// Optional sum saturation on signed overflow: define CLA_ADDER_SAT_EN.

module cla_block4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       gBlk,
    output logic       pBlk
);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    always_comb begin
        g = a & b;
        p = a ^ b;

        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                    | (p[2] & p[1] & p[0] & cin);

        s    = p ^ c;
        gBlk = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                    | (p[3] & p[2] & p[1] & g[0]);
        pBlk = &p;
    end
endmodule

module cla_lookahead #(
    parameter int unsigned NB = 8
) (
    input  logic [NB-1:0] g,
    input  logic [NB-1:0] p,
    output logic [NB:0]   c
);
    logic term;

    // Each block carry-in is a flat OR of G[k] & P[k+1..j-1] products (carry-in 0),
    // so no carry chain passes through the blocks.
    always_comb begin
        c    = '0;
        term = 1'b0;
        for (int unsigned j = 1; j <= NB; j++) begin
            for (int unsigned k = 0; k < j; k++) begin
                term = g[k];
                for (int unsigned m = k + 1; m < j; m++) begin
                    term = term & p[m];
                end
                c[j] = c[j] | term;
            end
        end
    end
endmodule

module cla_adder #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    output logic [N-1:0] sum,
    output logic         carry,
    output logic         overflow
);
    localparam int unsigned NB = N / 4;

    logic [N-1:0] rawSum;
    logic [NB-1:0] blkG;
    logic [NB-1:0] blkP;
    logic [NB:0]   blkC;
    logic         rawOverflow;
    logic [N-1:0] nextSum;

    for (genvar blk = 0; blk < NB; blk++) begin : gBlocks
        cla_block4 uBlock (
            .a    (a[4*blk +: 4]),
            .b    (b[4*blk +: 4]),
            .cin  (blkC[blk]),
            .s    (rawSum[4*blk +: 4]),
            .gBlk (blkG[blk]),
            .pBlk (blkP[blk])
        );
    end

    cla_lookahead #(.NB(NB)) uLookahead (
        .g (blkG),
        .p (blkP),
        .c (blkC)
    );

    always_comb begin
        rawOverflow = (a[N-1] == b[N-1]) && (rawSum[N-1] != a[N-1]);
`ifdef CLA_ADDER_SAT_EN
        if (rawOverflow) begin
            nextSum = a[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end else begin
            nextSum = rawSum;
        end
`else
        nextSum = rawSum;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum      <= nextSum;
                carry    <= blkC[NB];
                overflow <= rawOverflow;
            end
        end
    end
endmodule

// File: tb/tb_cla_adder.sv
// Self-checking bench for cla_adder at N=32 and N=8: vector table, handshake/reset
// sequences and random sweeps, all checked through a per-cycle expected-result queue.

module tb_cla_adder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        inValid32, inValid8;
    logic [31:0] a32, b32, sum32;
    logic [7:0]  a8, b8, sum8;
    logic        outValid32, carry32, overflow32;
    logic        outValid8, carry8, overflow8;

    always #5 clk = ~clk;

    cla_adder #(.N(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid32), .a(a32), .b(b32),
        .out_valid(outValid32), .sum(sum32), .carry(carry32), .overflow(overflow32)
    );

    cla_adder #(.N(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid8), .a(a8), .b(b8),
        .out_valid(outValid8), .sum(sum8), .carry(carry8), .overflow(overflow8)
    );

    typedef struct {
        logic        v;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] s;
        logic        c;
        logic        o;
    } vec_t;

    int   tests = 0;
    int   fails = 0;
    vec_t q32[$];
    vec_t q8[$];
    logic [31:0] held32S, held8S;
    logic        held32C, held32O, held8C, held8O;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic vec_t model(input logic v, input logic [31:0] a, input logic [31:0] b,
                                   input int unsigned w);
        vec_t r;
        logic [32:0] full;
        logic [31:0] mask;
        logic        sa, sb, ss;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 1);
        full = {1'b0, a & mask} + {1'b0, b & mask};
        sa = a[w-1];
        sb = b[w-1];
        ss = full[w-1];
        r.v = v;
        r.a = a & mask;
        r.b = b & mask;
        r.s = full[31:0] & mask;
        r.c = full[w];
        r.o = (sa == sb) && (ss != sa);
`ifdef CLA_ADDER_SAT_EN
        if (r.o) r.s = sa ? (32'h1 << (w - 1)) : (mask >> 1);
`endif
        return r;
    endfunction

    task automatic step32(input vec_t e);
        vec_t got;
        inValid32 = e.v;
        a32 = e.a;
        b32 = e.b;
        q32.push_back(e);
        @(posedge clk);
        #2;
        got = q32.pop_front();
        chk("valid32", {63'b0, outValid32}, {63'b0, got.v});
        if (got.v) begin
            held32S = got.s;
            held32C = got.c;
            held32O = got.o;
        end
        chk("sum32", {32'b0, sum32}, {32'b0, held32S});
        chk("carry32", {63'b0, carry32}, {63'b0, held32C});
        chk("ovf32", {63'b0, overflow32}, {63'b0, held32O});
    endtask

    task automatic step8(input vec_t e);
        vec_t got;
        inValid8 = e.v;
        a8 = e.a[7:0];
        b8 = e.b[7:0];
        q8.push_back(e);
        @(posedge clk);
        #2;
        got = q8.pop_front();
        chk("valid8", {63'b0, outValid8}, {63'b0, got.v});
        if (got.v) begin
            held8S = got.s;
            held8C = got.c;
            held8O = got.o;
        end
        chk("sum8", {56'b0, sum8}, {32'b0, held8S});
        chk("carry8", {63'b0, carry8}, {63'b0, held8C});
        chk("ovf8", {63'b0, overflow8}, {63'b0, held8O});
    endtask

    task automatic chkZero(input string tag);
        chk({tag, "_valid32"}, {63'b0, outValid32}, 64'd0);
        chk({tag, "_sum32"}, {32'b0, sum32}, 64'd0);
        chk({tag, "_carry32"}, {63'b0, carry32}, 64'd0);
        chk({tag, "_ovf32"}, {63'b0, overflow32}, 64'd0);
        chk({tag, "_valid8"}, {63'b0, outValid8}, 64'd0);
        chk({tag, "_sum8"}, {56'b0, sum8}, 64'd0);
    endtask

    vec_t table32[8];

    initial begin
        table32[0] = '{1'b1, 32'h0000_0007, 32'h33C3_D1E3, 32'h33C3_D1EA, 1'b0, 1'b0};
        table32[1] = '{1'b1, 32'hC000_0060, 32'hC34D_C31F, 32'h834D_C37F, 1'b1, 1'b0};
        table32[2] = '{1'b1, 32'h41E8_000E, 32'h8000_00F1, 32'hC1E8_00FF, 1'b0, 1'b0};
`ifdef CLA_ADDER_SAT_EN
        table32[3] = '{1'b1, 32'h4380_1555, 32'h401D_40AA, 32'h7FFF_FFFF, 1'b0, 1'b1};
        table32[4] = '{1'b1, 32'hC03D_0000, 32'h8000_499B, 32'h8000_0000, 1'b1, 1'b1};
        table32[6] = '{1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1};
`else
        table32[3] = '{1'b1, 32'h4380_1555, 32'h401D_40AA, 32'h839D_55FF, 1'b0, 1'b1};
        table32[4] = '{1'b1, 32'hC03D_0000, 32'h8000_499B, 32'h403D_499B, 1'b1, 1'b1};
        table32[6] = '{1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1};
`endif
        table32[5] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};
        table32[7] = '{1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0};

        rst_n = 1'b0;
        inValid32 = 1'b0; a32 = '0; b32 = '0;
        inValid8 = 1'b0;  a8 = '0;  b8 = '0;
        held32S = '0; held32C = 1'b0; held32O = 1'b0;
        held8S = '0;  held8C = 1'b0;  held8O = 1'b0;
        #1;
        chkZero("reset");
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Back-to-back table vectors, one result per cycle.
        for (int i = 0; i < 8; i++) step32(table32[i]);
        step32(table32[1]);

        // Reset while an operation is in flight.
        inValid32 = 1'b1;
        a32 = 32'h1234_5678;
        b32 = 32'h1111_1111;
        #2;
        rst_n = 1'b0;
        #1;
        chkZero("asyncRst");
        @(posedge clk);
        #2;
        chkZero("rstHold");
        rst_n = 1'b1;
        inValid32 = 1'b0;
        held32S = '0; held32C = 1'b0; held32O = 1'b0;
        held8S = '0;  held8C = 1'b0;  held8O = 1'b0;
        step32(model(1'b0, 32'h0, 32'h0, 32));

        // Valid pattern 1,0,1 with sum held on the idle cycle.
        step32(model(1'b1, 32'h0000_1000, 32'h0000_0234, 32));
        step32(model(1'b0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 32));
        step32(model(1'b1, 32'h8000_0000, 32'h8000_0000, 32));
        step32(model(1'b0, 32'h0, 32'h0, 32));

        for (int i = 0; i < 200; i++) begin
            step32(model(($urandom_range(0, 3) != 0), $urandom, $urandom, 32));
        end

        for (int i = 0; i < 200; i++) begin
            step8(model(($urandom_range(0, 3) != 0), $urandom, $urandom, 8));
        end
        step8(model(1'b1, 32'h7F, 32'h01, 8));
        step8(model(1'b1, 32'h80, 32'hFF, 8));
        step8(model(1'b1, 32'hFF, 32'h01, 8));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cla_adder.md
CLA_ADDER -- requirements
Module: cla_adder

Interface
REQ-001 SHALL have parameter N, default 32, meaning operand/result width; legal values are multiples of 4, from 4 to 64.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, operands on a/b are valid this cycle.
REQ-005 SHALL have port a, input, N, first operand, two's complement.
REQ-006 SHALL have port b, input, N, second operand, two's complement.
REQ-007 SHALL have port out_valid, output, 1, result registers hold a new result this cycle.
REQ-008 SHALL have port sum, output, N, registered sum bits.
REQ-009 SHALL have port carry, output, 1, registered unsigned carry-out of bit N-1.
REQ-010 SHALL have port overflow, output, 1, registered signed-overflow flag.

Function
REQ-011 SHALL compute a+b with carry-in 0 using carry-lookahead: 4-bit blocks with bit generate g=a&b and propagate p=a^b; in-block carries from lookahead equations; block group G/P feeding a second-level lookahead unit that produces the block carry-ins. No ripple chain across blocks.
REQ-012 SHALL form raw sum bit i as p[i]^c[i], and carry as c[N].
REQ-013 SHALL set overflow = (a[N-1]==b[N-1]) && (raw sum[N-1]!=a[N-1]).
REQ-014 SHALL have fixed 1-cycle latency: operands sampled at edge k with in_valid=1 -> sum/carry/overflow updated and out_valid=1 after edge k.
REQ-015 When in_valid=0 at an edge: out_valid SHALL go 0 and sum/carry/overflow SHALL hold their previous values.
REQ-016 Back-to-back in_valid=1 SHALL give one result per cycle; there is no backpressure or stall.
REQ-017 Without saturation, sum SHALL wrap modulo 2^N; carry and overflow are independent flags, so both may be 1 at once.
REQ-018 Outputs SHALL depend only on registered state and have no combinational path from inputs.

Reset
REQ-019 rst_n=0 SHALL immediately, without waiting for a clock edge, force out_valid=0, sum=0, carry=0 and overflow=0.
REQ-020 Reset asserted mid-operation SHALL discard any operation in flight; after rst_n rises, the first result comes from the first in_valid=1 edge.

Configuration
REQ-021 Macro CLA_ADDER_SAT_EN defined: on overflow=1, sum SHALL saturate to {0,1...1} when both operands are non-negative and to {1,0...0} when both are negative. Overflow and carry still report the raw values.
REQ-022 Macro CLA_ADDER_SAT_EN undefined: sum SHALL be the wrapped raw sum and no saturation logic is built.

Verification
REQ-023 Positive + positive: a=0x00000007, b=0x33C3D1E3 -> sum=0x33C3D1EA, carry=0, overflow=0, out_valid=1 one cycle later.
REQ-024 Negative + negative: a=0xC0000060, b=0xC34DC31F -> sum=0x834DC37F, carry=1, overflow=0.
REQ-025 Mixed signs: a=0x41E8000E, b=0x800000F1 -> sum=0xC1E800FF, carry=0, overflow=0.
REQ-026 Positive overflow: a=0x43801555, b=0x401D40AA -> overflow=1, carry=0; sum=0x839D55FF without the macro, 0x7FFFFFFF with CLA_ADDER_SAT_EN.
REQ-027 Negative overflow: a=0xC03D0000, b=0x8000499B -> overflow=1, carry=1; sum=0x403D499B without the macro, 0x80000000 with CLA_ADDER_SAT_EN.
REQ-028 Reset and handshake: drive rst_n=0 mid-stream -> all outputs 0 immediately. Then in_valid pulse pattern 1,0,1 -> out_valid pattern 1,0,1 delayed one cycle, with sum held during the 0 cycle.
REQ-029 Bench SHALL also sweep random a/b for N=32 and N=8 against a+b reference, and cover the carry-ripple boundary case a=0xFFFFFFFF, b=0x00000001 -> sum=0, carry=1, overflow=0.
